// File: rtl/rtc_bus_pkg.sv
// Shared types and defaults for the RTC bus engine and its phase timer.
// Holds no logic, so it adds no latency.
// Holds no logic, so it has no backpressure behaviour.
package rtc_bus_pkg;

    // Per-phase timing states. The timer walks these once for every bus phase.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        GAP
    } state_t;

    // Bus phase kinds. A write commit reuses PH_CMD because it drives the same
    // command word with ad=0 and a WR strobe.
    typedef enum logic [1:0] {
        PH_ADDR,
        PH_DATA,
        PH_CMD,
        PH_RDATA
    } phase_t;

    // Transfer command written to the RTC. Top-level CMD_WORD defaults to this value.
    localparam logic [7:0] DEF_CMD_WORD = 8'hF0;

    // Width of the phase down-counter. This bounds every T_x to 65536 cycles.
    localparam int CNT_W = 16;

endpackage

// File: rtl/rtc_phase_timer.sv
// Runs the SETUP/PULSE/HOLD/GAP timing of one bus phase and drives registered strobes.
// Latency: SETUP begins on the edge where start is seen; a phase lasts T_SETUP+T_PULSE+T_HOLD+T_GAP cycles.
// Backpressure: start is honoured only in IDLE or on the final GAP cycle (done); it is ignored at other times.
module rtc_phase_timer
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = 4,
    parameter int T_PULSE = 8,
    parameter int T_HOLD  = 4,
    parameter int T_GAP   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic strobe_rd,
    output logic done,
    output logic pulse_last,
    output logic cs_n,
    output logic rd_n,
    output logic wr_n,
    output logic oe
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_rd_q, sel_rd_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic             oe_q, oe_d;
    logic             win;

    assign done       = (state_q == GAP)   && (cnt_q == '0);
    assign pulse_last = (state_q == PULSE) && (cnt_q == '0);

    // Next state, counter reload and strobe outputs. Outputs are derived from the next state so that they register together with it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_rd_d = sel_rd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETUP;
                    cnt_d    = CNT_W'(T_SETUP - 1);
                    sel_rd_d = strobe_rd;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(T_PULSE - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(T_GAP - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (start) begin
                        state_d  = SETUP;
                        cnt_d    = CNT_W'(T_SETUP - 1);
                        sel_rd_d = strobe_rd;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // The RD strobe and the output enable are both qualified by sel_rd, so they can never be active in the same cycle.
        win    = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
        cs_n_d = ~win;
        rd_n_d = ~((state_d == PULSE) && sel_rd_d);
        wr_n_d = ~((state_d == PULSE) && !sel_rd_d);
        oe_d   = win && !sel_rd_d;
    end

    // Phase FSM with registered strobes. Reset idles the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_rd_q <= 1'b0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_rd_q <= sel_rd_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            oe_q     <= oe_d;
        end
    end

    assign cs_n = cs_n_q;
    assign rd_n = rd_n_q;
    assign wr_n = wr_n_q;
    assign oe   = oe_q;

endmodule

// File: rtl/rtc_bus_engine.sv
// RTC multiplexed A/D bus engine: sequences write and burst-read transactions. Build option RTC_CRONO_EN adds the chrono-run bit merge.
// Latency at default timing: a write takes 60 cycles from acceptance to ready; read word k returns at cycle 53+60k.
// Backpressure: req_ready is high only when idle; a request that arrives while busy is dropped, not queued.
module rtc_bus_engine
    import rtc_bus_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter int                 T_SETUP   = 4,
    parameter int                 T_PULSE   = 8,
    parameter int                 T_HOLD    = 4,
    parameter int                 T_GAP     = 4,
    parameter int                 BURST_MAX = 16,
    parameter logic [DATA_W-1:0]  CMD_WORD  = DATA_W'(DEF_CMD_WORD)
`ifdef RTC_CRONO_EN
    ,
    parameter logic [DATA_W-1:0]  CRONO_ADDR = '0,
    parameter logic [DATA_W-1:0]  CRONO_MASK = DATA_W'(8'h08)
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [DATA_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [$clog2(BURST_MAX)-1:0]  req_len,
`ifdef RTC_CRONO_EN
    input  logic                          crono_run,
`endif
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_last,
    output logic                          busy,
    output logic                          cs_n,
    output logic                          rd_n,
    output logic                          wr_n,
    output logic                          ad,
    output logic [DATA_W-1:0]             bus_out,
    output logic                          bus_oe,
    input  logic [DATA_W-1:0]             bus_in
);

    localparam int LEN_W = $clog2(BURST_MAX);

    if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_GAP < 1) begin : g_bad_timing
        $error("rtc_bus_engine: every T_x must be at least 1");
    end
    if (BURST_MAX < 2) begin : g_bad_burst
        $error("rtc_bus_engine: BURST_MAX must be at least 2");
    end

    logic              active_q, active_d;
    phase_t            phase_q, phase_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ad_q, ad_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic [DATA_W-1:0] samp_q, samp_d;
    logic              samp_pend_q, samp_pend_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_last_q, rd_last_d;

    logic              tmr_start;
    logic              tmr_rd;
    logic              tmr_done;
    logic              tmr_pulse_last;
    logic [DATA_W-1:0] wdata_in;
    logic [31:0]       len_in;

`ifdef RTC_CRONO_EN
    // While the chronometer runs, writes to its control register keep the run bit set.
    assign wdata_in = (req_write && crono_run && (req_addr == CRONO_ADDR)) ?
                      (req_wdata | CRONO_MASK) : req_wdata;
`else
    assign wdata_in = req_wdata;
`endif

    rtc_phase_timer #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_GAP   (T_GAP)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (tmr_start),
        .strobe_rd  (tmr_rd),
        .done       (tmr_done),
        .pulse_last (tmr_pulse_last),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .oe         (bus_oe)
    );

    // Acceptance and phase sequencing. The next phase starts on the edge that ends the previous GAP, so phases run back to back.
    always_comb begin
        active_d  = active_q;
        phase_d   = phase_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        len_d     = len_q;
        ad_d      = ad_q;
        bus_out_d = bus_out_q;
        tmr_start = 1'b0;
        tmr_rd    = 1'b0;
        len_in    = 32'(req_len);

        if (!active_q) begin
            if (req_valid) begin
                active_d  = 1'b1;
                write_d   = req_write;
                addr_d    = req_addr;
                wdata_d   = wdata_in;
                if (req_write) begin
                    len_d = '0;
                end else if (len_in > 32'(BURST_MAX - 1)) begin
                    len_d = LEN_W'(BURST_MAX - 1);
                end else begin
                    len_d = req_len;
                end
                phase_d   = req_write ? PH_ADDR : PH_CMD;
                tmr_start = 1'b1;
            end
        end else if (tmr_done) begin
            case (phase_q)
                PH_ADDR: begin
                    phase_d   = write_q ? PH_DATA : PH_RDATA;
                    tmr_start = 1'b1;
                end
                PH_DATA: begin
                    phase_d   = PH_CMD;
                    tmr_start = 1'b1;
                end
                PH_CMD: begin
                    if (write_q) begin
                        active_d = 1'b0;
                    end else begin
                        phase_d   = PH_ADDR;
                        tmr_start = 1'b1;
                    end
                end
                default: begin
                    if (len_q == '0) begin
                        active_d = 1'b0;
                    end else begin
                        len_d     = len_q - LEN_W'(1);
                        addr_d    = addr_q + DATA_W'(1);
                        phase_d   = PH_CMD;
                        tmr_start = 1'b1;
                    end
                end
            endcase
        end

        // ad and the drive value are loaded when a phase starts, so they are stable for the whole SETUP period.
        if (tmr_start) begin
            tmr_rd = (phase_d == PH_RDATA);
            ad_d   = (phase_d == PH_DATA) || (phase_d == PH_RDATA);
            case (phase_d)
                PH_ADDR: bus_out_d = addr_d;
                PH_DATA: bus_out_d = wdata_d;
                PH_CMD:  bus_out_d = CMD_WORD;
                default: bus_out_d = bus_out_q;
            endcase
        end
    end

    // Read return: capture bus_in on the last RD-low cycle, then present it one edge later together with the valid and last flags.
    always_comb begin
        samp_pend_d = active_q && (phase_q == PH_RDATA) && tmr_pulse_last;
        samp_d      = samp_pend_d ? bus_in : samp_q;
        rd_valid_d  = samp_pend_q;
        rd_data_d   = samp_pend_q ? samp_q : rd_data_q;
        rd_last_d   = samp_pend_q && (len_q == '0);
    end

    // Transaction and datapath registers. Reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q    <= 1'b0;
            phase_q     <= PH_ADDR;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            len_q       <= '0;
            ad_q        <= 1'b0;
            bus_out_q   <= '0;
            samp_q      <= '0;
            samp_pend_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            active_q    <= active_d;
            phase_q     <= phase_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            ad_q        <= ad_d;
            bus_out_q   <= bus_out_d;
            samp_q      <= samp_d;
            samp_pend_q <= samp_pend_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign req_ready = ~active_q;
    assign busy      = active_q;
    assign ad        = ad_q;
    assign bus_out   = bus_out_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_rtc_bus_engine.sv
// Directed bench for rtc_bus_engine at default timing (20-cycle bus phases).
// Sample n is taken 1 time unit after the n-th rising edge following acceptance.
// Includes a small RTC model that returns data based on the last address written.
module tb_rtc_bus_engine;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [3:0] req_len;
`ifdef RTC_CRONO_EN
    logic       crono_run;
`endif
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       busy;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;

    int checks = 0;
    int errors = 0;

    logic       tr_cs    [200];
    logic       tr_wr    [200];
    logic       tr_rd    [200];
    logic       tr_ad    [200];
    logic       tr_oe    [200];
    logic [7:0] tr_bus   [200];
    logic       tr_rdy   [200];
    logic       tr_rv    [200];
    logic [7:0] tr_rdat  [200];
    logic       tr_rlast [200];

    rtc_bus_engine dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
`ifdef RTC_CRONO_EN
        .crono_run (crono_run),
`endif
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .ad        (ad),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .bus_in    (bus_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RTC chip model: latches the last value written in an ad=0 phase and returns a fixed data pattern for that address.
    logic [7:0] last_ad;
    always @(posedge clk or posedge reset) begin
        if (reset) last_ad <= 8'h00;
        else if (!wr_n && !ad && bus_oe) last_ad <= bus_out;
    end

    function automatic logic [7:0] rtc_read(input logic [7:0] a);
        if (a == 8'h22) return 8'h59;
        return a ^ 8'h5A;
    endfunction

    assign bus_in = rtc_read(last_ad);

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            tr_cs[i]    = cs_n;
            tr_wr[i]    = wr_n;
            tr_rd[i]    = rd_n;
            tr_ad[i]    = ad;
            tr_oe[i]    = bus_oe;
            tr_bus[i]   = bus_out;
            tr_rdy[i]   = req_ready;
            tr_rv[i]    = rd_valid;
            tr_rdat[i]  = rd_data;
            tr_rlast[i] = rd_last;
        end
    endtask

    // Issues one request. Returns at sample 0 with req_valid low and the request inputs scrambled.
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [3:0] l);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_len   = l;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 8'hAA;
        req_wdata = 8'h55;
        req_len   = 4'hF;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL %s: timeout waiting for req_ready, got %b want 1", name, req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cs_n !== 1'b1)    begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        checks++; if (wr_n !== 1'b1)    begin errors++; $display("FAIL reset_wr_n: got %b want 1", wr_n); end
        checks++; if (rd_n !== 1'b1)    begin errors++; $display("FAIL reset_rd_n: got %b want 1", rd_n); end
        checks++; if (bus_oe !== 1'b0)  begin errors++; $display("FAIL reset_oe: got %b want 0", bus_oe); end
        checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h want 00", bus_out); end
        checks++; if (ad !== 1'b0)      begin errors++; $display("FAIL reset_ad: got %b want 0", ad); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready: got rdy=%b busy=%b want 1/0", req_ready, busy); end
        checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_rd: got v=%b l=%b d=%h want 0/0/00", rd_valid, rd_last, rd_data);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write;
        logic [7:0] exp_bus [3];
        logic       exp_ad  [3];
        int         lo;
        exp_bus[0] = 8'h21; exp_bus[1] = 8'h45; exp_bus[2] = 8'hF0;
        exp_ad[0]  = 1'b0;  exp_ad[1]  = 1'b1;  exp_ad[2]  = 1'b0;
        wait_idle("write_pre");
        send(1'b1, 8'h21, 8'h45, 4'h0);
        capture(62);
        for (int p = 0; p < 3; p++) begin
            lo = 0;
            for (int i = 20 * p; i < 20 * p + 20; i++) if (tr_wr[i] === 1'b0) lo++;
            checks++; if (lo != 8) begin errors++; $display("FAIL write_wr_low_p%0d: got %0d cycles want 8", p, lo); end
            checks++; if (tr_bus[20*p+4] !== exp_bus[p]) begin errors++; $display("FAIL write_bus_p%0d: got %h want %h", p, tr_bus[20*p+4], exp_bus[p]); end
            checks++; if (tr_ad[20*p+4] !== exp_ad[p]) begin errors++; $display("FAIL write_ad_p%0d: got %b want %b", p, tr_ad[20*p+4], exp_ad[p]); end
            checks++; if (tr_oe[20*p+4] !== 1'b1 || tr_cs[20*p+4] !== 1'b0) begin errors++; $display("FAIL write_oe_p%0d: got oe=%b cs_n=%b want 1/0", p, tr_oe[20*p+4], tr_cs[20*p+4]); end
            checks++; if (tr_oe[20*p+17] !== 1'b0 || tr_cs[20*p+17] !== 1'b1) begin errors++; $display("FAIL write_gap_p%0d: got oe=%b cs_n=%b want 0/1", p, tr_oe[20*p+17], tr_cs[20*p+17]); end
        end
        checks++; if (tr_rdy[0] !== 1'b0)  begin errors++; $display("FAIL write_ready_drop: got %b want 0", tr_rdy[0]); end
        checks++; if (tr_rdy[59] !== 1'b0) begin errors++; $display("FAIL write_ready_59: got %b want 0", tr_rdy[59]); end
        checks++; if (tr_rdy[60] !== 1'b1) begin errors++; $display("FAIL write_ready_60: got %b want 1", tr_rdy[60]); end
    endtask

    task automatic test_read_single;
        int rlo, wlo, nv, ov;
        wait_idle("read_pre");
        send(1'b0, 8'h22, 8'h00, 4'h0);
        capture(62);
        rlo = 0; wlo = 0; nv = 0; ov = 0;
        for (int i = 40; i < 60; i++) begin
            if (tr_rd[i] === 1'b0) rlo++;
            if (tr_wr[i] === 1'b0) wlo++;
        end
        for (int i = 0; i < 62; i++) begin
            if (tr_rv[i] === 1'b1) nv++;
            if (tr_oe[i] === 1'b1 && tr_rd[i] === 1'b0) ov++;
        end
        checks++; if (tr_bus[4] !== 8'hF0)  begin errors++; $display("FAIL read_cmd_bus: got %h want f0", tr_bus[4]); end
        checks++; if (tr_bus[24] !== 8'h22) begin errors++; $display("FAIL read_addr_bus: got %h want 22", tr_bus[24]); end
        checks++; if (tr_oe[44] !== 1'b0 || tr_rd[44] !== 1'b0 || tr_ad[44] !== 1'b1) begin
            errors++; $display("FAIL read_rdata_phase: got oe=%b rd_n=%b ad=%b want 0/0/1", tr_oe[44], tr_rd[44], tr_ad[44]);
        end
        checks++; if (rlo != 8) begin errors++; $display("FAIL read_rd_low: got %0d want 8", rlo); end
        checks++; if (wlo != 0) begin errors++; $display("FAIL read_no_wr_in_rdata: got %0d want 0", wlo); end
        checks++; if (nv != 1)  begin errors++; $display("FAIL read_valid_count: got %0d want 1", nv); end
        checks++; if (tr_rv[53] !== 1'b1 || tr_rlast[53] !== 1'b1) begin errors++; $display("FAIL read_valid_53: got v=%b l=%b want 1/1", tr_rv[53], tr_rlast[53]); end
        checks++; if (tr_rdat[53] !== 8'h59) begin errors++; $display("FAIL read_data: got %h want 59", tr_rdat[53]); end
        checks++; if (ov != 0)  begin errors++; $display("FAIL read_oe_rd_overlap: got %0d cycles want 0", ov); end
        checks++; if (tr_rdy[60] !== 1'b1) begin errors++; $display("FAIL read_ready_60: got %b want 1", tr_rdy[60]); end
    endtask

    task automatic test_burst;
        logic [7:0] exp_addr [3];
        logic [7:0] exp_dat  [3];
        logic       exp_last [3];
        int         nv;
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
        exp_dat[0]  = 8'hA4; exp_dat[1]  = 8'hA5; exp_dat[2]  = 8'h5A;
        exp_last[0] = 1'b0;  exp_last[1] = 1'b0;  exp_last[2] = 1'b1;
        wait_idle("burst_pre");
        send(1'b0, 8'hFE, 8'h00, 4'h2);
        capture(182);
        nv = 0;
        for (int i = 0; i < 182; i++) if (tr_rv[i] === 1'b1) nv++;
        checks++; if (nv != 3) begin errors++; $display("FAIL burst_valid_count: got %0d want 3", nv); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (tr_bus[60*k+24] !== exp_addr[k]) begin errors++; $display("FAIL burst_addr_%0d: got %h want %h", k, tr_bus[60*k+24], exp_addr[k]); end
            checks++; if (tr_rv[60*k+53] !== 1'b1) begin errors++; $display("FAIL burst_valid_%0d: got %b want 1", k, tr_rv[60*k+53]); end
            checks++; if (tr_rdat[60*k+53] !== exp_dat[k]) begin errors++; $display("FAIL burst_data_%0d: got %h want %h", k, tr_rdat[60*k+53], exp_dat[k]); end
            checks++; if (tr_rlast[60*k+53] !== exp_last[k]) begin errors++; $display("FAIL burst_last_%0d: got %b want %b", k, tr_rlast[60*k+53], exp_last[k]); end
        end
        checks++; if (tr_rdy[180] !== 1'b1) begin errors++; $display("FAIL burst_ready_180: got %b want 1", tr_rdy[180]); end
    endtask

    task automatic test_reset_mid;
        int bad;
        wait_idle("rstmid_pre");
        send(1'b1, 8'h21, 8'h45, 4'h0);
        repeat (26) @(posedge clk);
        #1;
        checks++; if (wr_n !== 1'b0 || bus_out !== 8'h45) begin errors++; $display("FAIL rstmid_in_pulse: got wr_n=%b bus=%h want 0/45", wr_n, bus_out); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (cs_n !== 1'b1 || wr_n !== 1'b1 || bus_oe !== 1'b0) begin
            errors++; $display("FAIL rstmid_immediate: got cs_n=%b wr_n=%b oe=%b want 1/1/0", cs_n, wr_n, bus_oe);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (cs_n !== 1'b1 || wr_n !== 1'b1 || rd_n !== 1'b1 || bus_oe !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_residual: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_back_to_back;
        int nr, wlo;
        wait_idle("b2b_pre");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h30;
        req_wdata = 8'h31;
        req_len   = 4'h0;
        @(posedge clk);
        #1;
        capture(62);
        nr = 0; wlo = 0;
        for (int i = 0; i < 60; i++) begin
            if (tr_rdy[i] === 1'b1) nr++;
            if (tr_wr[i] === 1'b0) wlo++;
        end
        checks++; if (nr != 0)   begin errors++; $display("FAIL b2b_ready_while_busy: got %0d cycles want 0", nr); end
        checks++; if (wlo != 24) begin errors++; $display("FAIL b2b_single_txn: got %0d wr_n-low cycles want 24", wlo); end
        checks++; if (tr_rdy[60] !== 1'b1) begin errors++; $display("FAIL b2b_ready_60: got %b want 1", tr_rdy[60]); end
        checks++; if (tr_rdy[61] !== 1'b0 || tr_cs[61] !== 1'b0) begin
            errors++; $display("FAIL b2b_second_accept: got rdy=%b cs_n=%b want 0/0", tr_rdy[61], tr_cs[61]);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_crono;
        logic [7:0] exp;
        wait_idle("crono_pre");
`ifdef RTC_CRONO_EN
        crono_run = 1'b1;
        exp = 8'h09;
`else
        exp = 8'h01;
`endif
        send(1'b1, 8'h00, 8'h01, 4'h0);
`ifdef RTC_CRONO_EN
        crono_run = 1'b0;
`endif
        capture(30);
        checks++; if (tr_bus[24] !== exp || tr_ad[24] !== 1'b1) begin
            errors++; $display("FAIL crono_data: got %h ad=%b want %h ad=1", tr_bus[24], tr_ad[24], exp);
        end
        checks++; if (tr_bus[4] !== 8'h00) begin errors++; $display("FAIL crono_addr: got %h want 00", tr_bus[4]); end
        wait_idle("crono_post");
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        req_len   = 4'h0;
`ifdef RTC_CRONO_EN
        crono_run = 1'b0;
`endif
        test_reset;
        test_write;
        test_read_single;
        test_burst;
        test_reset_mid;
        test_back_to_back;
        test_crono;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_engine.md
Name: rtc_bus_engine

Overview:
- Parametrised transaction engine for a multiplexed-address/data RTC bus with CS, RD, WR and A/D strobes.
- Successor to the fixed-timing RTC protocol driver. Adds configurable phase timing and width, a request/ready handshake, and multi-word burst reads with a per-word valid strobe.
- The bidirectional pad is split into out/oe/in; the top level ties these to the inout pin.
- Sits between the clock/date control FSM and the RTC chip.

Parameters:
- DATA_W, 8, bus/address/data width
- T_SETUP, 4, clk cycles CS low with bus/AD stable before strobe
- T_PULSE, 8, clk cycles RD or WR held low
- T_HOLD, 4, clk cycles after strobe release, CS still low, bus still driven
- T_GAP, 4, clk cycles CS high between bus phases
- BURST_MAX, 16, max words per read burst
- CMD_WORD, 8'hF0, transfer command written to the RTC (DATA_W wide)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  transaction request
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_addr  in  DATA_W  register address (burst start)
- req_wdata  in  DATA_W  write data
- req_len  in  $clog2(BURST_MAX)  read words minus 1; ignored for writes
- rd_valid  out  1  one-cycle pulse per read word
- rd_data  out  DATA_W  read word, held until next rd_valid
- rd_last  out  1  qualifies final rd_valid of a burst
- busy  out  1  = ~req_ready
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active low
- ad  out  1  0 = address/command phase, 1 = data phase
- bus_out  out  DATA_W  pad drive value
- bus_oe  out  1  pad output enable
- bus_in  in  DATA_W  pad input

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-transaction):
  - cs_n = rd_n = wr_n = 1, ad = 0, bus_oe = 0, bus_out = 0.
  - rd_valid = rd_last = 0, rd_data = 0, req_ready = 1.
  - FSM returns to IDLE; all counters cleared.
- Acceptance:
  - Request accepted on the clk edge where req_valid & req_ready.
  - req_addr, req_wdata, req_write and req_len are latched at acceptance. Later input changes are ignored.
  - req_ready drops the cycle after acceptance.
- Timing FSM: states IDLE, SETUP, PULSE, HOLD, GAP, driven by a down-counter loaded with T_x-1 on entry to each state.
  - SETUP: cs_n = 0; ad and bus drive valid.
  - PULSE: the phase's strobe = 0.
  - HOLD: strobe = 1, cs_n = 0.
  - GAP: cs_n = 1, bus_oe = 0.
  - One bus phase = T_SETUP + T_PULSE + T_HOLD + T_GAP cycles, 20 at defaults.
- Phase sequencer (2-bit index):
  - Write: ADDR (ad=0, WR, drive addr) -> DATA (ad=1, WR, drive wdata) -> COMMIT (ad=0, WR, drive CMD_WORD). Then IDLE.
  - Read word: CMD (ad=0, WR, drive CMD_WORD) -> ADDR (ad=0, WR, drive addr) -> RDATA (ad=1, RD, bus_oe=0).
  - bus_in is sampled on the last PULSE cycle of RDATA. rd_data and rd_valid update on the following edge.
  - Burst: after each RDATA GAP, addr increments by 1 (wraps modulo 2^DATA_W) and the word counter decrements.
  - rd_last is set with the word where the counter equals 0; then IDLE.
- bus_oe:
  - High from SETUP through HOLD of WR phases.
  - Never high while rd_n = 0.
  - Never simultaneously with rd_n low in the same cycle, including phase boundaries.
- Latency:
  - Write: 60 cycles acceptance-to-IDLE at defaults.
  - Read: first rd_valid at cycle 3*20-T_HOLD-T_GAP+1 after acceptance; each further word 60 cycles later.
- Boundaries:
  - req_len = 0 gives a single word.
  - req_len > BURST_MAX-1 is clamped to BURST_MAX-1.
  - req_valid held during busy is ignored, not queued.
  - Any T_x = 0 is illegal; elaboration asserts T_x >= 1.

Optional Feature:
- Macro: RTC_CRONO_EN
- With the macro: adds inputs crono_run (1) and parameters CRONO_ADDR = 0, CRONO_MASK = 8'h08.
  - A write to CRONO_ADDR while crono_run = 1 at acceptance drives (req_wdata | CRONO_MASK) in the DATA phase.
  - Read data from CRONO_ADDR is unaffected.
- Without the macro: no port; write data passes unmodified.

Decomposition:
- Package rtc_bus_pkg:
  - state enum (IDLE/SETUP/PULSE/HOLD/GAP)
  - phase enum (PH_ADDR/PH_DATA/PH_CMD/PH_RDATA)
  - default CMD_WORD
- One sub-module rtc_phase_timer: counter plus state sequencing for a single bus phase, with start/done handshake and a strobe-select input. The top level owns phase sequencing, the burst counter and datapath.

Test Plan:
- Write addr 8'h21, data 8'h45 -> three WR phases driving 21, 45, F0 with ad 0/1/0; each wr_n low exactly 8 cycles; req_ready back at cycle 60.
- Read addr 8'h22, req_len 0, RTC model returns 8'h59 -> bus shows F0, 22, then oe=0 with rd_n low 8 cycles; rd_valid=rd_last=1 once, rd_data=59.
- Burst read from 8'hFE, req_len 2 -> addresses FE, FF, 00 issued; three rd_valid pulses 60 cycles apart; rd_last only on third.
- Assert reset during PULSE of a write DATA phase -> same-cycle cs_n=wr_n=1, bus_oe=0; after release req_ready=1 and no residual strobes.
- req_valid held continuously through a write -> exactly one transaction accepted; second accepted only after return to IDLE.
- RTC_CRONO_EN defined, crono_run=1, write addr 00 data 8'h01 -> DATA phase drives 8'h09. Undefined -> drives 8'h01.
